icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only L1 instruction cache between the fetch stage and the block-read instruction memory.
//  Hits return one word in the same cycle; misses stall fetch and refill a whole block from memory.
//  Memory side drives the memory's ren/block_address and consumes its ready/dout block.
// PARAMETERS
//  ADDR_W       32  byte-address width from fetch
//  WORD_W       32  instruction word width
//  BLOCK_WORDS   4  words per line (power of 2); BLOCK_W = WORD_W*BLOCK_WORDS
//  NUM_LINES    16  lines (power of 2)
//  Derived: OFF_W = log2(BLOCK_WORDS)+2, IDX_W = log2(NUM_LINES), TAG_W = ADDR_W-IDX_W-OFF_W
// PORTS
//  clock           in   1             system clock
//  reset           in   1             async, active-high
//  cpu_ren         in   1             fetch request
//  cpu_addr        in   ADDR_W        byte address; bits [1:0] ignored
//  flush           in   1             invalidate all lines (pulse)
//  cpu_stall       out  1             1 = cpu_dout not valid, hold request
//  cpu_dout        out  WORD_W        instruction word, valid when cpu_ren & ~cpu_stall
//  mem_ren         out  1             block read request
//  mem_block_addr  out  ADDR_W-OFF_W  block address (cpu_addr >> OFF_W)
//  mem_ready       in   1             block valid on mem_din this cycle
//  mem_din         in   BLOCK_W       block data, word i at bits [i*WORD_W +: WORD_W]
// BEHAVIOUR
//  Reset (async, immediate): all valid bits 0, state IDLE, mem_ren=0, mem_block_addr=0, flush_pend=0, cpu_stall=0.
//   Tag/data arrays not reset.
//  Address split: tag=[ADDR_W-1:IDX_W+OFF_W], idx=[IDX_W+OFF_W-1:OFF_W], word=[OFF_W-1:2].
//  FSM states: IDLE, FETCH, FILL.
//  IDLE: hit = cpu_ren & valid[idx] & tag match; combinational.
//   - cpu_dout = data[idx][word], cpu_stall=0 on hit (0-cycle hit latency).
//   - cpu_ren=0: stall=0, cpu_dout don't-care, no memory traffic.
//   - Miss: stall=1; latch miss block address; next edge -> FETCH with mem_ren=1 and mem_block_addr registered.
//  FETCH: stall=1; mem_ren held 1, address held stable until mem_ready=1.
//   - Memory restarts its latency count if ren drops, so the request is never withdrawn early.
//   - On mem_ready=1: write mem_din, tag, valid=1 into line idx of the latched address.
//     Same edge: mem_ren<=0, state -> FILL.
//  FILL: stall=1, mem_ren=0 (one idle cycle so memory delay counter rearms); -> IDLE.
//   - IDLE re-looks up the current cpu_addr; if fetch changed address, a new miss is legal.
//  Miss penalty = memory latency + 2 cycles from miss detection to hit.
//  Flush: in IDLE with no outstanding miss, clears all valid bits at the edge.
//   - A hit in the flush cycle is still returned.
//   - In FETCH/FILL: sets flush_pend; fill completes normally.
//     On entry to IDLE, flush_pend forces one stall cycle that clears valid and flush_pend, then lookup resumes.
//  Flush asserted together with miss detection in IDLE: flush applied, miss proceeds to FETCH.
//  mem_ready outside FETCH is ignored. Simultaneous fill and flush_pend set: fill written, later cleared.
//  Reset mid-FETCH: request abandoned at once (mem_ren=0); no partial line written.
// STRUCTURE
//  Constants (ICACHE_LINES, ICACHE_BLOCK_WORDS, derived widths, FSM state encodings) go in constants.vh as `defines.
//  Sub-module icache_line_array: valid vector (async reset, bulk clear), tag + data arrays.
//   - Combinational read port, single write port for fills.
//  Top holds FSM, miss-address register, flush_pend, word select.
// TESTING (BLOCK_WORDS=4, NUM_LINES=16: idx=addr[7:4], tag=addr[31:8])
//  1 Cold miss: reset, cpu_ren=1 addr 0x00 -> stall=1, mem_ren=1 block 0x0.
//    mem_ready with words {D3,D2,D1,D0} -> 2 cycles later stall=0, dout=D0.
//    Then 0x4, 0x8, 0xC hit same cycle -> D1, D2, D3, mem_ren stays 0.
//  2 Conflict: after 1, addr 0x100 -> miss, block 0x10, refills idx 0; then 0x00 -> miss again, block 0x0.
//  3 Flush in IDLE: after fill of 0x00, pulse flush -> next access 0x00 misses (mem_ren=1, block 0x0).
//  4 Flush during FETCH: line 0x20 fills, extra stall cycle on return to IDLE, then 0x20 misses again.
//  5 Reset mid-FETCH -> mem_ren=0 and stall=0 same cycle; after release 0x00 misses.
//    Late mem_ready causes no array write.
//  6 cpu_ren=0 for 10 cycles -> stall=0, mem_ren=0 throughout.
//    Slow memory (20-cycle latency) -> mem_ren continuous, mem_block_addr stable until mem_ready.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
// The address is split into tag, line index, word select and the byte offset within a word.
package icache_dm_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 4;
    localparam int unsigned NUM_LINES   = 16;

    localparam int unsigned BLOCK_W = WORD_W * BLOCK_WORDS;
    localparam int unsigned WSEL_W  = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_W   = WSEL_W + 2;
    localparam int unsigned IDX_W   = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned BADDR_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

endpackage

// File: rtl/icache_dm_line_array.sv
// Line storage for the cache: a resettable valid vector with bulk clear, plus
// tag and data arrays. Reads are combinational; a single port writes fills.
module icache_dm_line_array
    import icache_dm_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];

    // Clear wins, though the controller never fills and clears in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
        if (clear) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-cycle hits in IDLE, whole-block
// refill on a miss, and flush that is deferred while a refill is outstanding.
module icache_dm
    import icache_dm_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_ren,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic               flush,
    output logic               cpu_stall,
    output logic [WORD_W-1:0]  cpu_dout,
    output logic               mem_ren,
    output logic [BADDR_W-1:0] mem_block_addr,
    input  logic               mem_ready,
    input  logic [BLOCK_W-1:0] mem_din
);

    state_e             state_q, state_d;
    logic [BADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic               mem_ren_q, mem_ren_d;
    logic               flush_pend_q, flush_pend_d;

    logic               stall_c, clear_c, wr_en_c, hit_c;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [BLOCK_W-1:0] rd_data;
    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [WSEL_W-1:0]  addr_word;
    logic               unused_addr_lsb;

    assign addr_tag        = cpu_addr[ADDR_W-1 -: TAG_W];
    assign addr_idx        = cpu_addr[OFF_W +: IDX_W];
    assign addr_word       = cpu_addr[2 +: WSEL_W];
    assign unused_addr_lsb = ^cpu_addr[1:0];

    icache_dm_line_array u_lines (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear_c),
        .wr_en    (wr_en_c),
        .wr_idx   (miss_addr_q[IDX_W-1:0]),
        .wr_tag   (miss_addr_q[BADDR_W-1 -: TAG_W]),
        .wr_data  (mem_din),
        .rd_idx   (addr_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    assign hit_c = cpu_ren & rd_valid & (rd_tag == addr_tag);

    always_comb begin
        cpu_dout = '0;
        for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
            if (addr_word == WSEL_W'(i)) begin
                cpu_dout = rd_data[i*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            miss_addr_q  <= '0;
            mem_ren_q    <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            mem_ren_q    <= mem_ren_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // The request stays up until mem_ready: dropping it would restart the memory's latency count.
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        mem_ren_d    = mem_ren_q;
        flush_pend_d = flush_pend_q;
        stall_c      = 1'b0;
        clear_c      = 1'b0;
        wr_en_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flush_pend_q) begin
                    stall_c      = 1'b1;
                    clear_c      = 1'b1;
                    flush_pend_d = 1'b0;
                end else begin
                    clear_c = flush;
                    if (cpu_ren && !hit_c) begin
                        stall_c     = 1'b1;
                        miss_addr_d = cpu_addr[ADDR_W-1:OFF_W];
                        mem_ren_d   = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                stall_c = 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ready) begin
                    wr_en_c   = 1'b1;
                    mem_ren_d = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                stall_c = 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held so fetch sees an idle cache immediately.
    assign cpu_stall      = stall_c & ~reset;
    assign mem_ren        = mem_ren_q;
    assign mem_block_addr = miss_addr_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a latency-configurable block memory model plus
// hand-computed expectations for hits, misses, conflicts, flush and reset.
module tb_icache_dm;

    logic         clock;
    logic         reset;
    logic         cpu_ren;
    logic [31:0]  cpu_addr;
    logic         flush;
    logic         cpu_stall;
    logic [31:0]  cpu_dout;
    logic         mem_ren;
    logic [27:0]  mem_block_addr;
    logic         mem_ready;
    logic [127:0] mem_din;

    logic         auto_mem;
    logic         auto_ready;
    logic [127:0] auto_din;
    logic         man_ready;
    logic [127:0] man_din;
    int           mem_lat;
    int           mem_cnt;

    int total;
    int bad;

    icache_dm dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_ren        (cpu_ren),
        .cpu_addr       (cpu_addr),
        .flush          (flush),
        .cpu_stall      (cpu_stall),
        .cpu_dout       (cpu_dout),
        .mem_ren        (mem_ren),
        .mem_block_addr (mem_block_addr),
        .mem_ready      (mem_ready),
        .mem_din        (mem_din)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_ready = auto_mem ? auto_ready : man_ready;
    assign mem_din   = auto_mem ? auto_din   : man_din;

    // Word at word-address w holds 0x5A000000 + w.
    function automatic logic [127:0] blk_data(input logic [27:0] b);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) begin
            d[i*32 +: 32] = 32'h5A00_0000 + 32'({b, 2'(i)});
        end
        return d;
    endfunction

    // Memory answers mem_lat cycles after ren rises; restarts if ren drops.
    always @(negedge clock) begin
        if (reset || !mem_ren) begin
            mem_cnt    = 0;
            auto_ready = 1'b0;
        end else if (auto_ready) begin
            mem_cnt    = 0;
            auto_ready = 1'b0;
        end else begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt >= mem_lat) begin
                auto_ready = 1'b1;
                auto_din   = blk_data(mem_block_addr);
                mem_cnt    = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_unstall(input string tag, input int max);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (cpu_stall && n < max);
        chk(tag, 32'(cpu_stall), 32'd0);
    endtask

    task automatic wait_ren_low(input string tag, input int max);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (mem_ren && n < max);
        chk(tag, 32'(mem_ren), 32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        auto_mem   = 1'b1;
        auto_ready = 1'b0;
        auto_din   = '0;
        man_ready  = 1'b0;
        man_din    = '0;
        mem_lat    = 1;
        mem_cnt    = 0;
        reset      = 1'b1;
        cpu_ren    = 1'b0;
        cpu_addr   = 32'h0;
        flush      = 1'b0;

        // Reset state
        tick();
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_ren", 32'(mem_ren), 32'd0);
        chk("rst_baddr", 32'(mem_block_addr), 32'h0);
        reset = 1'b0;

        // 1: cold miss with one-cycle memory, then same-line hits
        cpu_ren = 1'b1; cpu_addr = 32'h00; #1;
        chk("cold_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("cold_ren", 32'(mem_ren), 32'd1);
        chk("cold_baddr", 32'(mem_block_addr), 32'h0);
        tick();
        chk("cold_fill_ren", 32'(mem_ren), 32'd0);
        chk("cold_fill_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("cold_hit_stall", 32'(cpu_stall), 32'd0);
        chk("cold_d0", cpu_dout, 32'h5A00_0000);
        cpu_addr = 32'h04; #1;
        chk("hit_d1", cpu_dout, 32'h5A00_0001);
        chk("hit_d1_stall", 32'(cpu_stall), 32'd0);
        cpu_addr = 32'h08; #1;
        chk("hit_d2", cpu_dout, 32'h5A00_0002);
        cpu_addr = 32'h0F; #1;
        chk("hit_d3", cpu_dout, 32'h5A00_0003);
        tick();
        chk("hit_no_ren", 32'(mem_ren), 32'd0);

        // 2: conflict in index 0
        cpu_addr = 32'h100; #1;
        chk("conf_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("conf_baddr", 32'(mem_block_addr), 32'h10);
        wait_unstall("conf_fill", 10);
        chk("conf_d0", cpu_dout, 32'h5A00_0040);
        cpu_addr = 32'h00; #1;
        chk("conf_back_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("conf_back_ren", 32'(mem_ren), 32'd1);
        chk("conf_back_baddr", 32'(mem_block_addr), 32'h0);
        wait_unstall("conf_back_fill", 10);
        chk("conf_back_d0", cpu_dout, 32'h5A00_0000);

        // 3: flush in IDLE; the hit in the flush cycle still returns
        flush = 1'b1; cpu_addr = 32'h04; #1;
        chk("flush_hit_stall", 32'(cpu_stall), 32'd0);
        chk("flush_hit_d1", cpu_dout, 32'h5A00_0001);
        tick();
        flush = 1'b0; cpu_addr = 32'h00; #1;
        chk("flush_miss", 32'(cpu_stall), 32'd1);
        tick();
        chk("flush_miss_ren", 32'(mem_ren), 32'd1);
        chk("flush_miss_baddr", 32'(mem_block_addr), 32'h0);
        wait_unstall("flush_refill", 10);

        // 4: flush during FETCH is deferred until the fill completes
        mem_lat = 4;
        cpu_addr = 32'h20; #1;
        tick();
        chk("pend_ren", 32'(mem_ren), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ren_low("pend_fill", 10);
        chk("pend_fill_stall", 32'(cpu_stall), 32'd1);
        tick();
        chk("pend_extra_stall", 32'(cpu_stall), 32'd1);
        chk("pend_extra_ren", 32'(mem_ren), 32'd0);
        tick();
        chk("pend_remiss", 32'(cpu_stall), 32'd1);
        tick();
        chk("pend_remiss_ren", 32'(mem_ren), 32'd1);
        chk("pend_remiss_baddr", 32'(mem_block_addr), 32'h2);
        wait_unstall("pend_refill", 12);
        chk("pend_d0", cpu_dout, 32'h5A00_0008);

        // 6a: slow memory keeps the request and address stable
        mem_lat = 20;
        cpu_addr = 32'h3C; #1;
        tick();
        for (int i = 0; i < 18; i++) begin
            chk("slow_ren", 32'(mem_ren), 32'd1);
            chk("slow_baddr", 32'(mem_block_addr), 32'h3);
            tick();
        end
        wait_unstall("slow_fill", 10);
        chk("slow_d3", cpu_dout, 32'h5A00_000F);

        // 6b: no fetch request means no stall and no traffic
        cpu_ren = 1'b0; cpu_addr = 32'h900;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_stall", 32'(cpu_stall), 32'd0);
            chk("idle_ren", 32'(mem_ren), 32'd0);
        end

        // 5: reset mid-FETCH abandons the request; a late mem_ready writes nothing
        mem_lat = 2;
        auto_mem = 1'b0;
        cpu_ren = 1'b1; cpu_addr = 32'h50; #1;
        tick();
        chk("rfetch_ren", 32'(mem_ren), 32'd1);
        reset = 1'b1; #1;
        chk("rfetch_ren_drop", 32'(mem_ren), 32'd0);
        chk("rfetch_stall", 32'(cpu_stall), 32'd0);
        tick();
        reset = 1'b0; cpu_ren = 1'b0;
        @(negedge clock);
        man_ready = 1'b1;
        man_din   = blk_data(28'h5);
        tick();
        man_ready = 1'b0;
        cpu_ren = 1'b1; cpu_addr = 32'h00; #1;
        chk("rst_0_miss", 32'(cpu_stall), 32'd1);
        cpu_addr = 32'h50; #1;
        chk("late_rdy_nowrite", 32'(cpu_stall), 32'd1);
        auto_mem = 1'b1;
        tick();
        chk("rst_remiss_baddr", 32'(mem_block_addr), 32'h5);
        wait_unstall("rst_refill", 10);
        chk("rst_refill_d0", cpu_dout, 32'h5A00_0014);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
